pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
Parametrised program-counter and fetch-control unit for the LEGv8 datapath. It is the successor to the fixed 8-bit program counter.
- Generalised in address width, instruction step and reset vector.
- Adds a fetch handshake to instruction memory, stall, PC-relative and register branch redirect, halt, alignment fault and a fetch counter.
- Sits between the control unit/branch logic and instruction memory.

Parameters:
ADDR_W, 32, width of pc and all address ports
STEP, 4, bytes per instruction; power of two >= 1; SH = log2(STEP)
RESET_VEC, 0, pc value loaded on reset; must be STEP-aligned
OFF_W, 26, width of signed word offset for PC-relative branches
COUNT_W, 16, width of fetch counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
stall  in  1  hold pc; blocks fetch acceptance
imem_ready  in  1  instruction memory accepts the address this cycle
fetch_valid  out  1  pc is a valid fetch address
pc  out  ADDR_W  current fetch address
pc_plus_step  out  ADDR_W  pc + STEP, combinational, mod 2^ADDR_W
br_uncond  in  1  unconditional PC-relative branch (B)
br_cond  in  1  conditional PC-relative branch (CBZ)
cond_zero  in  1  CBZ condition; taken when br_cond & cond_zero
br_offset  in  OFF_W  signed word offset
br_reg  in  1  register branch (BR)
br_reg_target  in  ADDR_W  BR target address
halt  in  1  stop fetching
redirect  out  1  one-cycle pulse: pc was loaded with a branch target
align_fault  out  1  one-cycle pulse: BR target had nonzero low SH bits
halted  out  1  unit is in HALT
fetch_count  out  COUNT_W  accepted fetches, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, state=BOOT.
  - fetch_valid=0, redirect=0, align_fault=0, halted=0, fetch_count=0.
  - Reset asserted mid-operation aborts everything immediately. No pending request survives.
- States:
  - BOOT: fetch_valid=0. Next cycle goes to FETCH unconditionally. Gives one-cycle boot latency after reset release.
  - FETCH: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1. Leaves HALT only via reset.
- Accept: accept = fetch_valid & imem_ready & ~stall.
- Taken branch: taken = br_reg | br_uncond | (br_cond & cond_zero). Evaluated only in FETCH.
- Priority each FETCH cycle, highest first:
  1. halt: next state HALT; pc holds; branches ignored.
  2. br_reg: pc <= {br_reg_target[ADDR_W-1:SH], SH'b0}. align_fault=1 next cycle if the low SH bits were nonzero.
  3. br_uncond, or br_cond & cond_zero: pc <= pc + (sext(br_offset) << SH), mod 2^ADDR_W.
  4. accept: pc <= pc + STEP, mod 2^ADDR_W. 0xFFFFFFFC + 4 wraps to 0x00000000.
  5. Otherwise pc holds.
- Branches override stall and imem_ready. A redirect flushes the current fetch: it is not counted and pc loads the target regardless.
- redirect=1 in the cycle after any taken redirect (cases 2–3), else 0.
- fetch_count increments by 1 on accept with no redirect and no halt. It saturates at 2^COUNT_W-1, no wrap.
- br_cond with cond_zero=0 is not taken and behaves as case 4/5.
- Multiple branch inputs asserted together: highest priority wins. No fault is flagged.
- pc_plus_step is combinational from pc and is valid in every state.

Test Plan:
- Reset release, RESET_VEC=0x100, imem_ready=1 -> fetch_valid 0 for 1 cycle, then pc 0x100, 0x104, 0x108 on successive cycles; fetch_count=3 after those three cycles.
- pc=0x200, stall=1 for 3 cycles, then stall=0 -> pc stays 0x200 and count frozen for 3 cycles, then 0x204. Repeat with imem_ready=0 -> same response.
- pc=0x200, br_cond=1, cond_zero=1, br_offset=-2 -> next pc 0x1F8, redirect=1 one cycle, count unchanged. Same with cond_zero=0 -> pc 0x204.
- br_reg=1, br_reg_target=0x403, stall=1 -> pc 0x400, align_fault=1 and redirect=1 for one cycle.
- pc=0xFFFFFFFC, accept -> pc 0x00000000. With COUNT_W=2, 5 accepts -> fetch_count=3.
- halt=1 with br_uncond=1 in the same cycle -> pc unchanged, halted=1, fetch_valid=0, stays halted. Then reset=0 mid-HALT -> pc=RESET_VEC immediately, state BOOT.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch control for the LEGv8 datapath.
// Handles the fetch handshake, stall, PC-relative/register branches, halt and fetch counting.
module pc_fetch_ctrl #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        STEP      = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int unsigned        OFF_W     = 26,
  parameter int unsigned        COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               imem_ready,
  output logic               fetch_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus_step,
  input  logic               br_uncond,
  input  logic               br_cond,
  input  logic               cond_zero,
  input  logic [OFF_W-1:0]   br_offset,
  input  logic               br_reg,
  input  logic [ADDR_W-1:0]  br_reg_target,
  input  logic               halt,
  output logic               redirect,
  output logic               align_fault,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam int unsigned       SH        = $clog2(STEP);
  localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(STEP - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] rel_target;
  logic              redirect_nx;
  logic              fault_nx;
  logic              count_inc;
  logic              accept;
  logic              taken_rel;

  assign fetch_valid  = (state == S_FETCH);
  assign halted       = (state == S_HALT);
  assign pc_plus_step = pc + STEP_V;
  assign accept       = fetch_valid & imem_ready & ~stall;
  assign taken_rel    = br_uncond | (br_cond & cond_zero);

  // Masking with LOW_MASK instead of slicing keeps STEP=1 (SH=0) legal.
  assign off_sext   = ADDR_W'($signed(br_offset));
  assign rel_target = pc + (off_sext << SH);

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    redirect_nx = 1'b0;
    fault_nx    = 1'b0;
    count_inc   = 1'b0;
    case (state)
      S_BOOT:  state_nx = S_FETCH;
      S_FETCH: begin
        if (halt) begin
          state_nx = S_HALT;
        end else if (br_reg) begin
          pc_nx       = br_reg_target & ~LOW_MASK;
          redirect_nx = 1'b1;
          fault_nx    = |(br_reg_target & LOW_MASK);
        end else if (taken_rel) begin
          pc_nx       = rel_target;
          redirect_nx = 1'b1;
        end else if (accept) begin
          pc_nx     = pc_plus_step;
          count_inc = 1'b1;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      pc          <= RESET_VEC;
      redirect    <= 1'b0;
      align_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      redirect    <= redirect_nx;
      align_fault <= fault_nx;
      if (count_inc && (fetch_count != COUNT_MAX))
        fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule
